// File: rtl/decompress_unit.sv
// decompress_unit
//   Rebuilds IEEE-754 single-precision words from (status, payload) pairs
//   produced by the 2-bit-status float compressor. Two-stage pipeline with
//   valid/ready handshakes on both sides.
//
//   status 11 : payload is the float, passed bit-exact
//   status 10 : payload[31:16] = {sign, q[14:0]}, |x| = q * 2^-14
//   status 00 : zero
//   status 01 : illegal, emits zero and sets the sticky err_illegal flag
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     input pair valid
//   in_ready     block can accept a pair this cycle
//   in_status    pair status code
//   in_data      payload (status 10 uses only [31:16])
//   out_valid    dout valid
//   out_ready    consumer accepts dout
//   dout         reconstructed float
//   err_illegal  sticky: an illegal status was accepted
//   cnt_zero / cnt_half / cnt_full  saturating per-class accept counters,
//                present only when DECOMP_STATS_EN is defined (width CNT_W)
//
// Build option: define DECOMP_STATS_EN to add the statistics counters.

module decompress_unit
`ifdef DECOMP_STATS_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_status,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      dout,
  output logic             err_illegal
`ifdef DECOMP_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_half,
  output logic [CNT_W-1:0] cnt_full
`endif
);

  localparam logic [1:0] ST_ZERO = 2'b00;
  localparam logic [1:0] ST_ILL  = 2'b01;
  localparam logic [1:0] ST_HALF = 2'b10;
  localparam logic [1:0] ST_FULL = 2'b11;

  // stage 1: raw payload is kept whole because status 11 needs all 32 bits;
  // sign and q are its [31] and [30:16] slices
  logic        s1_valid;
  logic [1:0]  s1_status;
  logic [31:0] s1_data;
  logic [3:0]  s1_p;

  logic        adv1;
  logic        adv2;
  logic        accept;
  logic [3:0]  p_in;
  logic [14:0] s1_q;
  logic [22:0] mant;
  logic [31:0] dout_next;

  // in_ready depends only on registered state and out_ready
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && in_ready;

  // index of the leading one of q; zero when q is zero (result unused then)
  always_comb begin
    p_in = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (in_data[16+i]) p_in = 4'(i);
    end
  end

  // stage 2 datapath: normalise q so its leading one becomes the hidden bit
  always_comb begin
    s1_q      = s1_data[30:16];
    mant      = {8'b0, s1_q} << (5'd23 - {1'b0, s1_p});
    dout_next = 32'h0000_0000;
    case (s1_status)
      ST_FULL: dout_next = s1_data;
      ST_HALF: begin
        if (s1_q != 15'd0)
          dout_next = {s1_data[31], 8'd113 + {4'b0, s1_p}, mant};
      end
      default: dout_next = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_status   <= 2'b00;
      s1_data     <= 32'h0000_0000;
      s1_p        <= 4'd0;
      out_valid   <= 1'b0;
      dout        <= 32'h0000_0000;
      err_illegal <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_status <= in_status;
          s1_data   <= in_data;
          s1_p      <= p_in;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) dout <= dout_next;
      end
      if (accept && (in_status == ST_ILL)) err_illegal <= 1'b1;
    end
  end

`ifdef DECOMP_STATS_EN
  logic is_zero;
  logic is_half;
  logic is_full;

  // status 10 with q == 0 decodes to zero, so it is counted as a zero
  always_comb begin
    is_zero = 1'b0;
    is_half = 1'b0;
    is_full = 1'b0;
    case (in_status)
      ST_FULL: is_full = 1'b1;
      ST_HALF: begin
        if (in_data[30:16] != 15'd0) is_half = 1'b1;
        else                         is_zero = 1'b1;
      end
      default: is_zero = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_zero <= '0;
      cnt_half <= '0;
      cnt_full <= '0;
    end else if (accept) begin
      if (is_zero && (cnt_zero != '1)) cnt_zero <= cnt_zero + 1'b1;
      if (is_half && (cnt_half != '1)) cnt_half <= cnt_half + 1'b1;
      if (is_full && (cnt_full != '1)) cnt_full <= cnt_full + 1'b1;
    end
  end
`endif

endmodule
